// File: rtl/mips_cpu_bus.sv
// rtl/mips_cpu_bus.sv - multicycle MIPS-I subset CPU with one shared Avalon-style master port
// FETCH -> EXEC (-> MEM for LW); halts when a fetch would start at address 0.
module mips_cpu_bus #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALTED} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] npc_q;
  logic [31:0] ir_q;
  logic        hold_q;
  logic [31:0] gpr_q [32];

  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] simm;
  logic [31:0] zimm;
  logic [31:0] ea;
  logic [31:0] link;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic        is_lw;
  logic        is_sw;

  logic        wr_en_d;
  logic [4:0]  wr_idx_d;
  logic [31:0] wr_data_d;
  logic        taken_d;
  logic [31:0] target_d;

  // readdata is only guaranteed on the first EXEC cycle, so stalled EXEC and MEM use the latched copy
  assign instr  = (state_q == EXEC && !hold_q) ? readdata : ir_q;
  assign op     = instr[31:26];
  assign rs_idx = instr[25:21];
  assign rt_idx = instr[20:16];
  assign rd_idx = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  assign rs_val = gpr_q[rs_idx];
  assign rt_val = gpr_q[rt_idx];
  assign simm   = {{16{imm[15]}}, imm};
  assign zimm   = {16'h0000, imm};
  assign ea     = rs_val + simm;
  assign link   = pc_q + 32'd8;
  assign br_tgt = npc_q + (simm << 2);
  assign j_tgt  = {npc_q[31:28], instr[25:0], 2'b00};
  assign is_lw  = (op == 6'h23);
  assign is_sw  = (op == 6'h2B);

  assign active      = (state_q != HALTED);
  assign register_v0 = gpr_q[2];

  always_comb begin
    wr_en_d   = 1'b0;
    wr_idx_d  = rt_idx;
    wr_data_d = 32'h0;
    taken_d   = 1'b0;
    target_d  = br_tgt;
    case (op)
      6'h00: begin
        wr_en_d  = 1'b1;
        wr_idx_d = rd_idx;
        case (funct)
          6'h00: wr_data_d = rt_val << shamt;
          6'h02: wr_data_d = rt_val >> shamt;
          6'h03: wr_data_d = $signed(rt_val) >>> shamt;
          6'h04: wr_data_d = rt_val << rs_val[4:0];
          6'h06: wr_data_d = rt_val >> rs_val[4:0];
          6'h07: wr_data_d = $signed(rt_val) >>> rs_val[4:0];
          6'h08: begin
            wr_en_d  = 1'b0;
            taken_d  = 1'b1;
            target_d = rs_val;
          end
          6'h09: begin
            taken_d   = 1'b1;
            target_d  = rs_val;
            wr_data_d = link;
          end
          6'h21: wr_data_d = rs_val + rt_val;
          6'h23: wr_data_d = rs_val - rt_val;
          6'h24: wr_data_d = rs_val & rt_val;
          6'h25: wr_data_d = rs_val | rt_val;
          6'h26: wr_data_d = rs_val ^ rt_val;
          6'h27: wr_data_d = ~(rs_val | rt_val);
          6'h2A: wr_data_d = {31'h0, $signed(rs_val) < $signed(rt_val)};
          6'h2B: wr_data_d = {31'h0, rs_val < rt_val};
          default: wr_en_d = 1'b0;
        endcase
      end
      6'h02: begin
        taken_d  = 1'b1;
        target_d = j_tgt;
      end
      6'h03: begin
        taken_d   = 1'b1;
        target_d  = j_tgt;
        wr_en_d   = 1'b1;
        wr_idx_d  = 5'd31;
        wr_data_d = link;
      end
      6'h04: taken_d = (rs_val == rt_val);
      6'h05: taken_d = (rs_val != rt_val);
      6'h06: taken_d = ($signed(rs_val) <= 0);
      6'h07: taken_d = ($signed(rs_val) > 0);
      6'h09: begin wr_en_d = 1'b1; wr_data_d = rs_val + simm; end
      6'h0A: begin wr_en_d = 1'b1; wr_data_d = {31'h0, $signed(rs_val) < $signed(simm)}; end
      6'h0B: begin wr_en_d = 1'b1; wr_data_d = {31'h0, rs_val < simm}; end
      6'h0C: begin wr_en_d = 1'b1; wr_data_d = rs_val & zimm; end
      6'h0D: begin wr_en_d = 1'b1; wr_data_d = rs_val | zimm; end
      6'h0E: begin wr_en_d = 1'b1; wr_data_d = rs_val ^ zimm; end
      6'h0F: begin wr_en_d = 1'b1; wr_data_d = {imm, 16'h0000}; end
      default: ;
    endcase
  end

  // Reset gates the request lines immediately so an aborted access never reaches the slave
  always_comb begin
    read       = 1'b0;
    write      = 1'b0;
    byteenable = 4'h0;
    address    = pc_q;
    writedata  = rt_val;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          if (pc_q != 32'h0) begin
            read       = 1'b1;
            byteenable = 4'hF;
          end
        end
        EXEC: begin
          if (is_lw || is_sw) begin
            read       = is_lw;
            write      = is_sw;
            address    = ea & ~32'h3;
            byteenable = 4'hF;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_VECTOR;
      npc_q   <= RESET_VECTOR + 32'd4;
      ir_q    <= 32'h0;
      hold_q  <= 1'b0;
      for (int i = 0; i < 32; i++) gpr_q[i] <= 32'h0;
    end else begin
      case (state_q)
        FETCH: begin
          if (pc_q == 32'h0) begin
            state_q <= HALTED;
          end else if (!waitrequest) begin
            state_q <= EXEC;
            hold_q  <= 1'b0;
          end
        end
        EXEC: begin
          ir_q <= instr;
          if ((is_lw || is_sw) && waitrequest) begin
            hold_q <= 1'b1;
          end else begin
            pc_q  <= npc_q;
            npc_q <= taken_d ? target_d : npc_q + 32'd4;
            if (wr_en_d && wr_idx_d != 5'd0) gpr_q[wr_idx_d] <= wr_data_d;
            state_q <= is_lw ? MEM : FETCH;
          end
        end
        MEM: begin
          if (rt_idx != 5'd0) gpr_q[rt_idx] <= readdata;
          state_q <= FETCH;
        end
        default: state_q <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus.sv
// tb/tb_mips_cpu_bus.sv - directed self-checking bench for mips_cpu_bus
// Registered 1-cycle memory model with optional 3-cycle waitrequest stalls on every access.
module tb_mips_cpu_bus;

  logic        clk;
  logic        reset;
  logic        active;
  logic [31:0] register_v0;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  logic [31:0] rom [256];
  logic [31:0] ram [256];

  int n_cmp;
  int n_bad;

  logic        stall_en;
  int          stall_cnt;
  int          stab_checks;
  int          stab_bad;
  logic [69:0] snap;
  logic        wr_seen;
  logic [31:0] wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  localparam logic [31:0] JR0 = 32'h00000008;
  localparam logic [31:0] NOP = 32'h00000000;

  mips_cpu_bus dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .address(address), .read(read), .write(write), .byteenable(byteenable),
    .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial readdata = 32'h0;

  always @(posedge clk) begin
    if (!reset && !waitrequest) begin
      if (read) readdata <= (address[31:28] == 4'hB) ? rom[address[9:2]] : ram[address[9:2]];
      if (write && address[31:28] != 4'hB) ram[address[9:2]] <= writedata;
    end
  end

  // Stall generator and bus-stability monitor
  initial begin
    waitrequest = 1'b0;
    stall_cnt   = 0;
    stab_checks = 0;
    stab_bad    = 0;
    wr_seen     = 1'b0;
    wr_addr     = 32'h0;
    wr_be       = 4'h0;
    wr_data     = 32'h0;
    snap        = '0;
    forever begin
      @(negedge clk);
      if (waitrequest) begin
        stab_checks++;
        if ({address, read, write, byteenable, writedata} !== snap) stab_bad++;
      end
      snap = {address, read, write, byteenable, writedata};
      if (write) begin
        wr_seen = 1'b1;
        wr_addr = address;
        wr_be   = byteenable;
        wr_data = writedata;
      end
      if (stall_en && !reset && (read || write) && stall_cnt < 3) begin
        waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        waitrequest = 1'b0;
        stall_cnt   = 0;
      end
    end
  end

  function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rr(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] sh,
                                     input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = NOP;
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic wait_halt(output int cycles);
    cycles = 0;
    while (active && cycles < 300) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic run3(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                      output logic [31:0] v0);
    int cyc;
    clear_rom();
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = JR0; rom[4] = NOP;
    do_reset();
    wait_halt(cyc);
    v0 = register_v0;
  endtask

  task automatic load_store_prog();
    clear_rom();
    rom[0] = it(6'h09, 5'd0, 5'd2, 16'h0077);
    rom[1] = it(6'h0F, 5'd0, 5'd3, 16'hCAFE);
    rom[2] = it(6'h0D, 5'd3, 5'd3, 16'hF00D);
    rom[3] = it(6'h09, 5'd0, 5'd4, 16'h0200);
    rom[4] = it(6'h2B, 5'd4, 5'd3, 16'h0100);
    rom[5] = it(6'h23, 5'd4, 5'd2, 16'h0100);
    rom[6] = JR0;
    rom[7] = NOP;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = it(6'h09, 5'd0, 5'd2, 16'h1234);
    rom[1] = JR0;
    @(negedge clk); #1;
    n_cmp++;
    if ({read, write, byteenable} !== 6'b0) begin
      n_bad++; $display("FAIL reset_bus: got %b expected 000000", {read, write, byteenable});
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (active !== 1'b1) begin n_bad++; $display("FAIL reset_active: got %b expected 1", active); end
    n_cmp++;
    if (register_v0 !== 32'h0) begin n_bad++; $display("FAIL reset_v0: got %h expected 0", register_v0); end
    n_cmp++;
    if (address !== 32'hBFC00000) begin n_bad++; $display("FAIL reset_pc: got %h expected bfc00000", address); end
    n_cmp++;
    if ({read, byteenable} !== 5'b11111) begin
      n_bad++; $display("FAIL reset_fetch: got %b expected 11111", {read, byteenable});
    end
  endtask

  task automatic test_addiu();
    int cyc;
    clear_rom();
    rom[0] = it(6'h09, 5'd0, 5'd2, 16'h1234);
    rom[1] = JR0;
    rom[2] = NOP;
    do_reset();
    wait_halt(cyc);
    n_cmp++;
    if (register_v0 !== 32'h00001234) begin n_bad++; $display("FAIL addiu_v0: got %h expected 00001234", register_v0); end
    n_cmp++;
    if (cyc !== 7) begin n_bad++; $display("FAIL addiu_cycles: got %0d expected 7", cyc); end
    n_cmp++;
    if ({active, read, write} !== 3'b000) begin n_bad++; $display("FAIL halted_bus: got %b expected 000", {active, read, write}); end
  endtask

  task automatic test_lui_ori();
    int cyc;
    logic [31:0] v;
    clear_rom();
    rom[0] = it(6'h0F, 5'd0, 5'd2, 16'hDEAD);
    rom[1] = it(6'h0D, 5'd2, 5'd2, 16'hBEEF);
    rom[2] = JR0;
    rom[3] = NOP;
    do_reset();
    wait_halt(cyc);
    n_cmp++;
    if (register_v0 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lui_ori_v0: got %h expected deadbeef", register_v0); end
    n_cmp++;
    if (cyc !== 9) begin n_bad++; $display("FAIL lui_ori_cycles: got %0d expected 9", cyc); end
    run3(it(6'h09, 5'd0, 5'd2, 16'hFFFF), NOP, NOP, v);
    n_cmp++;
    if (v !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL addiu_neg: got %h expected ffffffff", v); end
  endtask

  task automatic test_sw_lw();
    int cyc;
    load_store_prog();
    clear_ram();
    wr_seen = 1'b0;
    do_reset();
    wait_halt(cyc);
    n_cmp++;
    if (wr_seen !== 1'b1) begin n_bad++; $display("FAIL sw_seen: got %b expected 1", wr_seen); end
    n_cmp++;
    if (wr_addr !== 32'h00000300) begin n_bad++; $display("FAIL sw_addr: got %h expected 00000300", wr_addr); end
    n_cmp++;
    if (wr_be !== 4'hF) begin n_bad++; $display("FAIL sw_be: got %h expected f", wr_be); end
    n_cmp++;
    if (wr_data !== 32'hCAFEF00D) begin n_bad++; $display("FAIL sw_data: got %h expected cafef00d", wr_data); end
    n_cmp++;
    if (ram[8'hC0] !== 32'hCAFEF00D) begin n_bad++; $display("FAIL sw_mem: got %h expected cafef00d", ram[8'hC0]); end
    n_cmp++;
    if (register_v0 !== 32'hCAFEF00D) begin n_bad++; $display("FAIL lw_v0: got %h expected cafef00d", register_v0); end
    n_cmp++;
    if (cyc !== 18) begin n_bad++; $display("FAIL sw_lw_cycles: got %0d expected 18", cyc); end
  endtask

  task automatic test_delay_slot();
    int cyc;
    clear_rom();
    rom[0] = it(6'h04, 5'd0, 5'd0, 16'h0002);
    rom[1] = it(6'h09, 5'd0, 5'd2, 16'h0001);
    rom[2] = it(6'h09, 5'd2, 5'd2, 16'h0005);
    rom[3] = it(6'h09, 5'd2, 5'd2, 16'h0010);
    rom[4] = JR0;
    rom[5] = NOP;
    do_reset();
    wait_halt(cyc);
    n_cmp++;
    if (register_v0 !== 32'd17) begin n_bad++; $display("FAIL beq_v0: got %h expected 00000011", register_v0); end
    n_cmp++;
    if (cyc !== 11) begin n_bad++; $display("FAIL beq_cycles: got %0d expected 11", cyc); end
    rom[0] = it(6'h05, 5'd0, 5'd0, 16'h0002);
    do_reset();
    wait_halt(cyc);
    n_cmp++;
    if (register_v0 !== 32'd22) begin n_bad++; $display("FAIL bne_v0: got %h expected 00000016", register_v0); end
    n_cmp++;
    if (cyc !== 13) begin n_bad++; $display("FAIL bne_cycles: got %0d expected 13", cyc); end
  endtask

  task automatic test_jump();
    int cyc;
    clear_rom();
    rom[0] = {6'h03, 26'h3F00003};
    rom[1] = NOP;
    rom[2] = it(6'h09, 5'd0, 5'd2, 16'h0055);
    rom[3] = rr(5'd31, 5'd0, 5'd2, 5'd0, 6'h21);
    rom[4] = JR0;
    rom[5] = NOP;
    do_reset();
    wait_halt(cyc);
    n_cmp++;
    if (register_v0 !== 32'hBFC00008) begin n_bad++; $display("FAIL jal_link: got %h expected bfc00008", register_v0); end
    n_cmp++;
    if (cyc !== 11) begin n_bad++; $display("FAIL jal_cycles: got %0d expected 11", cyc); end
    rom[0] = {6'h02, 26'h3F00003};
    rom[1] = it(6'h09, 5'd0, 5'd2, 16'h0001);
    rom[2] = it(6'h09, 5'd2, 5'd2, 16'h0002);
    rom[3] = it(6'h09, 5'd2, 5'd2, 16'h0004);
    do_reset();
    wait_halt(cyc);
    n_cmp++;
    if (register_v0 !== 32'd5) begin n_bad++; $display("FAIL j_v0: got %h expected 00000005", register_v0); end
  endtask

  task automatic test_alu();
    logic [31:0] w [11][3];
    logic [31:0] e [11];
    logic [31:0] v;
    w[0]  = '{it(6'h09, 0, 3, 16'hFFF8), rr(0, 3, 2, 5'd1, 6'h03), NOP};  e[0]  = 32'hFFFFFFFC;
    w[1]  = '{it(6'h09, 0, 3, 16'hFFF8), rr(0, 3, 2, 5'd28, 6'h02), NOP}; e[1]  = 32'h0000000F;
    w[2]  = '{it(6'h09, 0, 3, 16'hFFFF), rr(3, 0, 2, 0, 6'h2A), NOP};     e[2]  = 32'h00000001;
    w[3]  = '{it(6'h09, 0, 2, 16'h0009), it(6'h09, 0, 3, 16'hFFFF), rr(3, 0, 2, 0, 6'h2B)}; e[3] = 32'h0;
    w[4]  = '{it(6'h09, 0, 3, 16'h007F), rr(3, 0, 2, 0, 6'h27), NOP};     e[4]  = 32'hFFFFFF80;
    w[5]  = '{it(6'h09, 0, 3, 16'h0003), it(6'h09, 0, 5, 16'h0010), rr(3, 5, 2, 0, 6'h04)}; e[5] = 32'h80;
    w[6]  = '{it(6'h09, 0, 3, 16'h0005), rr(0, 3, 2, 0, 6'h23), NOP};     e[6]  = 32'hFFFFFFFB;
    w[7]  = '{it(6'h09, 0, 3, 16'hFFF0), it(6'h0C, 3, 2, 16'hFF0F), NOP}; e[7]  = 32'h0000FF00;
    w[8]  = '{it(6'h09, 0, 3, 16'h00F0), it(6'h0E, 3, 2, 16'hFFFF), NOP}; e[8]  = 32'h0000FF0F;
    w[9]  = '{it(6'h09, 0, 3, 16'hFFFC), it(6'h09, 0, 5, 16'h0001), rr(5, 3, 2, 0, 6'h07)}; e[9] = 32'hFFFFFFFE;
    w[10] = '{it(6'h09, 0, 0, 16'h0005), it(6'h09, 0, 2, 16'h0003), NOP}; e[10] = 32'h00000003;
    for (int k = 0; k < 11; k++) begin
      run3(w[k][0], w[k][1], w[k][2], v);
      n_cmp++;
      if (v !== e[k]) begin n_bad++; $display("FAIL alu_case%0d: got %h expected %h", k, v, e[k]); end
    end
  endtask

  task automatic test_waitrequest();
    int cyc;
    load_store_prog();
    clear_ram();
    stab_checks = 0;
    stab_bad    = 0;
    stall_en    = 1'b1;
    do_reset();
    wait_halt(cyc);
    stall_en = 1'b0;
    n_cmp++;
    if (register_v0 !== 32'hCAFEF00D) begin n_bad++; $display("FAIL stall_v0: got %h expected cafef00d", register_v0); end
    n_cmp++;
    if (cyc !== 48) begin n_bad++; $display("FAIL stall_cycles: got %0d expected 48", cyc); end
    n_cmp++;
    if (stab_checks !== 30) begin n_bad++; $display("FAIL stall_count: got %0d expected 30", stab_checks); end
    n_cmp++;
    if (stab_bad !== 0) begin n_bad++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", stab_bad); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int n;
    load_store_prog();
    clear_ram();
    do_reset();
    n = 0;
    while (write !== 1'b1 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    n_cmp++;
    if (write !== 1'b1) begin n_bad++; $display("FAIL mid_reach_sw: got write=%b expected 1", write); end
    n_cmp++;
    if (register_v0 !== 32'h77) begin n_bad++; $display("FAIL mid_v0_before: got %h expected 00000077", register_v0); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({read, write} !== 2'b00) begin n_bad++; $display("FAIL mid_gate: got %b expected 00", {read, write}); end
    @(negedge clk); #1;
    n_cmp++;
    if ({read, write, byteenable} !== 6'b0) begin
      n_bad++; $display("FAIL mid_next: got %b expected 000000", {read, write, byteenable});
    end
    n_cmp++;
    if (ram[8'hC0] !== 32'h0) begin n_bad++; $display("FAIL mid_no_store: got %h expected 0", ram[8'hC0]); end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({active, read, address} !== {2'b11, 32'hBFC00000}) begin
      n_bad++; $display("FAIL mid_restart: got %b %b %h expected 1 1 bfc00000", active, read, address);
    end
    n_cmp++;
    if (register_v0 !== 32'h0) begin n_bad++; $display("FAIL mid_v0_cleared: got %h expected 0", register_v0); end
    wait_halt(cyc);
    n_cmp++;
    if (register_v0 !== 32'hCAFEF00D) begin n_bad++; $display("FAIL mid_rerun_v0: got %h expected cafef00d", register_v0); end
    n_cmp++;
    if (cyc !== 18) begin n_bad++; $display("FAIL mid_rerun_cycles: got %0d expected 18", cyc); end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    reset    = 1'b1;
    stall_en = 1'b0;
    clear_ram();
    repeat (2) @(posedge clk);
    test_reset();
    test_addiu();
    test_lui_ori();
    test_sw_lw();
    test_delay_slot();
    test_jump();
    test_alu();
    test_waitrequest();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_cpu_bus.md
Name: mips_cpu_bus

Overview:
Multicycle 32-bit MIPS-I subset CPU with a single Avalon-style memory-mapped master port shared by instruction fetch and data access. It executes from reset vector 0xBFC00000 and halts when control transfers to address 0x00000000. Register $v0 is exported for test observation. This is the top-level CPU block; memory is external.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
active  output  1  1 while running, 0 once halted
register_v0  output  32  current contents of GPR $2, combinational from the register file
address  output  32  byte address, always word-aligned (bits [1:0]=0)
read  output  1  read request
write  output  1  write request
byteenable  output  4  lane enables; bit0 = readdata/writedata[7:0] = lowest byte address
writedata  output  32  store data
waitrequest  input  1  slave stall; current request must be held while high
readdata  input  32  read data, valid on the cycle after a read is accepted

Behaviour:
- Reset: the design samples reset only on a rising edge of clk.
  - PC=RESET_VECTOR, next-PC=RESET_VECTOR+4.
  - All 32 GPRs cleared; register_v0=0.
  - State=FETCH, active=1.
  - While reset is high: read=0, write=0, byteenable=0.
  - Reset asserted mid-instruction aborts the instruction with no register or memory side effect.
- $0 reads as 0; writes to it are ignored.
- The bus is little-endian.
- An access is accepted on a rising edge where read or write is high and waitrequest is low.
- While waitrequest is high, address, read, write, writedata and byteenable are held stable.
- States:
  - FETCH:
    - If PC==0: go to HALTED with no bus access.
    - Otherwise drive read=1, address=PC, byteenable=4'b1111.
    - On acceptance go to EXEC.
  - EXEC:
    - Instruction = readdata.
    - ALU ops, branches and jumps complete here; write the GPR and update the PC, then go to FETCH.
    - LW: drive read=1, address=rs+sext(imm), byteenable=1111. On acceptance go to MEM.
    - SW: drive write=1, address=rs+sext(imm), writedata=rt, byteenable=1111. On acceptance go to FETCH.
  - MEM: rt<=readdata, then go to FETCH.
  - HALTED:
    - active=0, read=0, write=0.
    - Remains here until reset.
- Branch delay slot: PC<=next-PC every instruction.
  - Taken branch/jump: next-PC<=target.
  - Otherwise next-PC<=next-PC+4.
  - The instruction after a branch always executes.
- Supported instructions:
  - R-type: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, JR, JALR.
  - I-type: ADDIU, ANDI, ORI, XORI, LUI, SLTI, SLTIU, BEQ, BNE, BLEZ, BGTZ, LW, SW.
  - J-type: J, JAL.
- Arithmetic rules:
  - ADDIU/SLTI/SLTIU/LW/SW sign-extend imm; ANDI/ORI/XORI zero-extend.
  - LUI: rt=imm<<16.
  - All adds wrap modulo 2^32; no overflow trap.
  - SLT compares signed, SLTU unsigned.
  - Shift amount: shamt, or rs[4:0] for the variable forms.
  - Branch target = address of delay slot + (sext(imm)<<2).
  - J target = {delay-slot PC[31:28], index, 2'b00}.
  - JAL writes $31 with PC+8; JALR writes rd with PC+8.
- Unsupported opcodes execute as NOP.
- Halting on JR $zero: the delay-slot instruction executes, then the next FETCH sees PC==0, active falls and the CPU halts.
- Latency without stalls:
  - Non-load instruction: 2 cycles.
  - LW: 3 cycles.
  - SW: 2 cycles.
  - Each waitrequest-high cycle adds one cycle.

Test Plan:
1. ADDIU $2,$0,0x1234; JR $0; NOP at 0xBFC00000, waitrequest=0, 1-cycle registered memory. Required: active falls within 20 cycles of reset release; register_v0=0x00001234.
2. LUI $2,0xDEAD; ORI $2,$2,0xBEEF; JR $0; NOP. Required: register_v0=0xDEADBEEF. ADDIU $2,$0,-1 then gives 0xFFFFFFFF.
3. SW $3,0x100($4) then LW $2,0x100($4) with $3=0xCAFEF00D and $4 a valid data base. Required: write=1 with the correct address and byteenable=1111, then register_v0=0xCAFEF00D.
4. Delay slot: BEQ $0,$0,+2; ADDIU $2,$0,1; ADDIU $2,$2,5 (skipped); ADDIU $2,$2,16. Required: register_v0=17. BNE not taken falls through.
5. waitrequest held high for 3 cycles during fetch and during LW. Required: bus outputs stable throughout, result identical to the zero-wait run, 3 extra cycles each.
6. Assert reset mid-program. Required: next cycle read=0, write=0; after release PC=0xBFC00000, register_v0=0, active=1, and the program reruns correctly.
